rotleft_seq: RTL
================

ROTLEFT_SEQ -- requirements
Module: rotleft_seq

Interface
REQ-001 Parameter WIDTH, default 32, word width in bits (power of two, >=8).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in_data  input  WIDTH  word to rotate left.
REQ-007 in_amt  input  $clog2(WIDTH)  left-rotate amount, 0..WIDTH-1.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 out_data  output  WIDTH  rotated word.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 Result SHALL equal in_data rotated left by in_amt bits: out_data[(i+amt) mod WIDTH] = in_data[i]; inverse of the fixed rotate-right units.
REQ-013 FSM states SHALL be IDLE, BUSY, DONE; in_ready SHALL be high only in IDLE.
REQ-014 Accept occurs on a clock edge with in_valid && in_ready; in_data and in_amt SHALL be registered on that edge (edge 0) and ignored afterwards.
REQ-015 On accept with in_amt==0 the block SHALL go directly to DONE, out_valid high in the cycle after edge 0, out_data = in_data.
REQ-016 On accept with in_amt!=0 the block SHALL go to BUSY with a remaining-count register loaded with in_amt.
REQ-017 In BUSY each edge SHALL rotate the working register left by one bit and decrement remaining by one; on the edge where remaining reaches 0 the state SHALL become DONE.
REQ-018 Latency: out_valid SHALL first be high in the cycle after edge N, N = number of steps (N = in_amt without REQ-026).
REQ-019 In DONE out_valid SHALL be high and out_data SHALL hold stable until out_valid && out_ready on an edge, then the state SHALL return to IDLE.
REQ-020 No overlap: a new request SHALL NOT be accepted on the same edge as the output handshake; earliest accept is the edge after return to IDLE.
REQ-021 out_data SHALL be the working register; in IDLE it SHALL retain the last result.
REQ-022 in_valid high outside IDLE SHALL have no effect; out_ready outside DONE SHALL have no effect.

Reset
REQ-023 While rst_n low: state IDLE, in_ready 1, out_valid 0, busy 0, out_data 0, remaining 0.
REQ-024 Reset asserted in BUSY or DONE SHALL abort the operation immediately (asynchronously) with no result delivered.
REQ-025 First accept possible on the first rising edge with rst_n high.

Configuration
REQ-026 Macro ROTLEFT_SEQ_BYTE_STEP_EN: when defined, a BUSY step with remaining>=8 SHALL rotate by 8 bits and subtract 8, otherwise 1 bit and subtract 1; steps N = amt/8 + amt%8.
REQ-027 Without the macro only 1-bit steps exist; function identical, latency N = in_amt; no 8-bit rotate logic synthesized.

Structure
REQ-028 Package rot_pkg SHALL hold ROT_WIDTH (32), the state enum typedef (IDLE/BUSY/DONE), and the step-size constant 8.
REQ-029 One sub-module rotleft_step: combinational rotate of the working word by one bit or, under the macro, by 8 bits, selected by a control input.

Verification
REQ-030 in_data=0x00000001, in_amt=22 -> out_data=0x00400000, out_valid after edge 22 (macro: edge 8).
REQ-031 in_data=0xD159E048, in_amt=22 -> out_data=0x12345678 (undoes right-rotate by 22).
REQ-032 in_data=0xA5A5A5A5, in_amt=0 -> out_valid in cycle after accept, out_data=0xA5A5A5A5, busy high only that cycle if out_ready high.
REQ-033 in_data=0x80000000, in_amt=31, out_ready held low 5 cycles after out_valid -> out_data=0x40000000 stable, in_ready low throughout, in_valid pulses ignored.
REQ-034 rst_n pulsed low at BUSY step 3 of in_amt=10 -> out_valid 0, out_data 0, in_ready 1 immediately; next request in_data=0x0000000F, in_amt=4 -> 0x000000F0.
REQ-035 Back-to-back: in_valid held high with two requests (0x1,1) then (0x1,2), out_ready high -> results 0x2 then 0x4, second accept one edge after first handshake.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared constants and types for the sequential left-rotate unit.
// Holds word width default, FSM state enum and the byte step size.
package rot_pkg;

    localparam int ROT_WIDTH  = 32;
    localparam int STEP_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rotleft_seq_if.sv
// Request/result handshake bundle for rotleft_seq.
// slave: in_valid/in_data/in_amt/out_ready in; in_ready/out_valid/out_data/busy out.
interface rotleft_seq_if
    import rot_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH
) ();

    localparam int AW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AW-1:0]    in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_amt,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        output in_amt,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );

endinterface

// File: rtl/rotleft_step.sv
// Combinational single step of the left rotate: by 1 bit, or by 8 bits
// when ROTLEFT_SEQ_BYTE_STEP_EN is defined and big is set.
// Ports: din (word), big (byte step select, macro only), dout (rotated).
module rotleft_step
    import rot_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH
) (
    input  logic [WIDTH-1:0] din,
`ifdef ROTLEFT_SEQ_BYTE_STEP_EN
    input  logic             big,
`endif
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] bit_rot;

    assign bit_rot = {din[WIDTH-2:0], din[WIDTH-1]};

`ifdef ROTLEFT_SEQ_BYTE_STEP_EN
    logic [WIDTH-1:0] byte_rot;

    // A byte rotate of an 8-bit word is the identity.
    if (WIDTH > STEP_BYTES) begin : g_byte
        assign byte_rot = {din[WIDTH-STEP_BYTES-1:0],
                           din[WIDTH-1 -: STEP_BYTES]};
    end else begin : g_ident
        assign byte_rot = din;
    end

    assign dout = big ? byte_rot : bit_rot;
`else
    assign dout = bit_rot;
`endif

endmodule

// File: rtl/rotleft_seq.sv
// Sequential left rotate: one request at a time, rotated in 1-bit steps
// (8-bit steps too when ROTLEFT_SEQ_BYTE_STEP_EN is defined).
// Ports: clk, rst_n (async, active-low), bus (rotleft_seq_if.slave).
module rotleft_seq
    import rot_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    rotleft_seq_if.slave  bus
);

    localparam int AW = $clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;
    logic [WIDTH-1:0] step_out;
    logic [AW-1:0]    rem_q;
    logic [AW-1:0]    rem_d;
    logic [AW-1:0]    step_amt;

`ifdef ROTLEFT_SEQ_BYTE_STEP_EN
    logic big;

    // int compare so the test also works when AW cannot hold 8.
    assign big      = int'(rem_q) >= STEP_BYTES;
    assign step_amt = big ? AW'(STEP_BYTES) : AW'(1);
`else
    assign step_amt = AW'(1);
`endif

    rotleft_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .din  (work_q),
`ifdef ROTLEFT_SEQ_BYTE_STEP_EN
        .big  (big),
`endif
        .dout (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d  = bus.in_data;
                    rem_d   = bus.in_amt;
                    state_d = (bus.in_amt == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                work_d = step_out;
                rem_d  = rem_q - step_amt;
                if (rem_q == step_amt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Returning to IDLE here keeps accept off this edge.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_data  = work_q;

endmodule
